// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: FSM states, default link geometry, slot-width helper.
package tdm_pkg;

    localparam int unsigned DEF_WIDTH      = 2;
    localparam int unsigned DEF_CHANNELS   = 4;
    localparam int unsigned DEF_MISS_LIMIT = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// TDM receive bus: serial slot input plus rebuilt parallel frame and status.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS
);
    logic [WIDTH-1:0]          tdm_in;
    logic                      frame_sync;
    logic [CHANNELS*WIDTH-1:0] ch_out;
    logic                      frame_valid;
    logic                      locked;
    logic                      sync_err;

    modport master (
        output tdm_in, frame_sync,
        input  ch_out, frame_valid, locked, sync_err
    );

    modport slave (
        input  tdm_in, frame_sync,
        output ch_out, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// Mod-CHANNELS slot counter with synchronous clear and load-to-1 (realign on slot 0).
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned SLOT_W  = slot_w(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load1,
    input  logic              advance,
    output logic [SLOT_W-1:0] cnt
);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(CHANNELS - 1);

    // Explicit compare against the last slot so non-power-of-2 frames wrap correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (clear)   cnt <= '0;
        else if (load1)   cnt <= SLOT_W'(1);
        else if (advance) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: aligns on the slot-0 marker, flywheels through missing markers,
// and publishes each complete frame as a parallel channel word.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned CHANNELS   = DEF_CHANNELS,
    parameter int unsigned MISS_LIMIT = DEF_MISS_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    tdm_demux_if.slave bus
);
    localparam int unsigned SLOT_W = slot_w(CHANNELS);
    localparam int unsigned MISS_W = slot_w(MISS_LIMIT + 1);
    localparam logic [SLOT_W-1:0] LAST      = SLOT_W'(CHANNELS - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    state_e                        state_q, state_d;
    logic [SLOT_W-1:0]             slot_cnt, cap_slot;
    logic [MISS_W-1:0]             miss_q, miss_d;
    logic                          cnt_clear, cnt_load1, cnt_adv;
    logic                          cap_en, deliver, err;
    logic [(CHANNELS-1)*WIDTH-1:0] shadow;
    logic [CHANNELS*WIDTH-1:0]     ch_q;
    logic                          fv_q, locked_q, err_q;

    tdm_slot_counter #(.CHANNELS(CHANNELS)) u_slot_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .load1   (cnt_load1),
        .advance (cnt_adv),
        .cnt     (slot_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        cnt_clear = 1'b0;
        cnt_load1 = 1'b0;
        cnt_adv   = 1'b0;
        cap_en    = 1'b0;
        cap_slot  = slot_cnt;
        deliver   = 1'b0;
        err       = 1'b0;
        case (state_q)
            HUNT: begin
                if (bus.frame_sync) begin
                    state_d   = LOCKED;
                    cnt_load1 = 1'b1;
                    cap_en    = 1'b1;
                    cap_slot  = '0;
                    miss_d    = '0;
                end
            end
            LOCKED: begin
                if (slot_cnt != '0) begin
                    if (bus.frame_sync) begin
                        // Misplaced marker: drop the partial frame and restart at slot 0.
                        err       = 1'b1;
                        cnt_load1 = 1'b1;
                        cap_en    = 1'b1;
                        cap_slot  = '0;
                        miss_d    = '0;
                    end else begin
                        cap_en  = 1'b1;
                        cnt_adv = 1'b1;
                        deliver = (slot_cnt == LAST);
                    end
                end else if (bus.frame_sync) begin
                    cap_en  = 1'b1;
                    cnt_adv = 1'b1;
                    miss_d  = '0;
                end else if (miss_q == MISS_LAST) begin
                    state_d   = HUNT;
                    cnt_clear = 1'b1;
                end else begin
                    miss_d  = miss_q + 1'b1;
                    cap_en  = 1'b1;
                    cnt_adv = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // The last slot bypasses the shadow and goes straight into the output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            ch_q     <= '0;
            fv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CHANNELS) - 1; i++) begin
                if (cap_en && (cap_slot == SLOT_W'(i)))
                    shadow[i*WIDTH +: WIDTH] <= bus.tdm_in;
            end
            if (deliver) ch_q <= {bus.tdm_in, shadow};
            fv_q     <= deliver;
            locked_q <= (state_d == LOCKED);
            err_q    <= err;
        end
    end

    assign bus.ch_out      = ch_q;
    assign bus.frame_valid = fv_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = err_q;
endmodule
